controle_movimento: RTL and testbench

//  Moves the player square once per video frame from the four direction buttons.

---
 rtl/controle_movimento.sv | 164 ++++++++++++++++
 tb/tb_controle_movimento.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/controle_movimento.sv
// Player-square motion controller: one move per frame from the buttons, with the
// X and Y candidates probed one after the other through a single shared collision checker.
module controle_movimento #(
    parameter int STEP      = 2,
    parameter int TAMANHO   = 20,
    parameter int CHECK_LAT = 2,
    parameter int X_INI     = 110,
    parameter int Y_INI     = 60,
    parameter int H_MAX     = 640,
    parameter int V_MAX     = 480
) (
    input  logic       VGA_clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       colisao,
    output logic [9:0] xCand,
    output logic [8:0] yCand,
    output logic [6:0] tamanho,
    output logic [9:0] xPos,
    output logic [8:0] yPos,
    output logic       busy,
    output logic       bloqueado,
    output logic       frame_perdido
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SET_X  = 3'd1;
    localparam logic [2:0] WAIT_X = 3'd2;
    localparam logic [2:0] SET_Y  = 3'd3;
    localparam logic [2:0] WAIT_Y = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam int          CW     = $clog2(CHECK_LAT + 1);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] X_LIM  = 11'(H_MAX - TAMANHO);
    localparam logic [10:0] Y_LIM  = 11'(V_MAX - TAMANHO);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    xpos_q, xpos_d, xcand_q, xcand_d;
    logic [8:0]    ypos_q, ypos_d, ycand_q, ycand_d;
    logic          xmv_q, xmv_d, xneg_q, xneg_d;
    logic          ymv_q, ymv_d, yneg_q, yneg_d;
    logic          bloq_q, bloq_d, perd_q, perd_d;
    logic [10:0]   x11, y11, tgt_x, tgt_y;

    // Targets are computed 11 bits wide so the +STEP side can be clamped without wrapping.
    always_comb begin
        x11 = {1'b0, xpos_q};
        y11 = {2'b0, ypos_q};
        if (xneg_q) tgt_x = (x11 < STEP11) ? 11'd0 : x11 - STEP11;
        else        tgt_x = (x11 + STEP11 > X_LIM) ? X_LIM : x11 + STEP11;
        if (yneg_q) tgt_y = (y11 < STEP11) ? 11'd0 : y11 - STEP11;
        else        tgt_y = (y11 + STEP11 > Y_LIM) ? Y_LIM : y11 + STEP11;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        xcand_d = xcand_q;
        ycand_d = ycand_q;
        xmv_d   = xmv_q;
        xneg_d  = xneg_q;
        ymv_d   = ymv_q;
        yneg_d  = yneg_q;
        bloq_d  = 1'b0;
        perd_d  = perd_q | (frame_tick && state_q != IDLE);
        case (state_q)
            IDLE: begin
                xcand_d = xpos_q;
                ycand_d = ypos_q;
                if (frame_tick) begin
                    xmv_d  = btn_right ^ btn_left;
                    xneg_d = btn_left;
                    ymv_d  = btn_down ^ btn_up;
                    yneg_d = btn_up;
                    if (btn_right ^ btn_left)   state_d = SET_X;
                    else if (btn_down ^ btn_up) state_d = SET_Y;
                end
            end
            SET_X: begin
                // Already at the edge: nothing to probe on this axis.
                if (tgt_x == x11) state_d = ymv_q ? SET_Y : DONE;
                else begin
                    xcand_d = tgt_x[9:0];
                    ycand_d = ypos_q;
                    cnt_d   = CW'(CHECK_LAT);
                    state_d = WAIT_X;
                end
            end
            WAIT_X: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    if (colisao) bloq_d = 1'b1;
                    else         xpos_d = xcand_q;
                    state_d = ymv_q ? SET_Y : DONE;
                end
            end
            SET_Y: begin
                if (tgt_y == y11) state_d = DONE;
                else begin
                    ycand_d = tgt_y[8:0];
                    xcand_d = xpos_q;
                    cnt_d   = CW'(CHECK_LAT);
                    state_d = WAIT_Y;
                end
            end
            WAIT_Y: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    if (colisao) bloq_d = 1'b1;
                    else         ypos_d = ycand_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge VGA_clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xpos_q  <= 10'(X_INI);
            ypos_q  <= 9'(Y_INI);
            xcand_q <= 10'(X_INI);
            ycand_q <= 9'(Y_INI);
            xmv_q   <= 1'b0;
            xneg_q  <= 1'b0;
            ymv_q   <= 1'b0;
            yneg_q  <= 1'b0;
            bloq_q  <= 1'b0;
            perd_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            xcand_q <= xcand_d;
            ycand_q <= ycand_d;
            xmv_q   <= xmv_d;
            xneg_q  <= xneg_d;
            ymv_q   <= ymv_d;
            yneg_q  <= yneg_d;
            bloq_q  <= bloq_d;
            perd_q  <= perd_d;
        end
    end

    assign xCand         = xcand_q;
    assign yCand         = ycand_q;
    assign tamanho       = 7'(TAMANHO);
    assign xPos          = xpos_q;
    assign yPos          = ypos_q;
    assign busy          = (state_q != IDLE);
    assign bloqueado     = bloq_q;
    assign frame_perdido = perd_q;
endmodule

// File: tb/tb_controle_movimento.sv
// Bench for controle_movimento: directed edge cases plus random frames against a per-frame
// position model; the collision checker is emulated from the candidate outputs.
module tb_controle_movimento;
    logic       VGA_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       colisao;
    logic [9:0] xCand, xPos;
    logic [8:0] yCand, yPos;
    logic [6:0] tamanho;
    logic       busy, bloqueado, frame_perdido;

    int n_chk = 0;
    int n_bad = 0;
    int mode  = 0;
    int mx    = 110;
    int my    = 60;

    controle_movimento dut (
        .VGA_clk(VGA_clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .colisao(colisao), .xCand(xCand), .yCand(yCand), .tamanho(tamanho),
        .xPos(xPos), .yPos(yPos), .busy(busy), .bloqueado(bloqueado),
        .frame_perdido(frame_perdido)
    );

    always #5 VGA_clk = ~VGA_clk;

    // Obstacle map: 0 none, 1 only horizontal moves blocked, 2 arithmetic pattern.
    function automatic bit blocked(int md, int cx, int cy, int px);
        if (md == 1) return cx != px;
        if (md == 2) return ((cx * 3 + cy * 5) % 7) < 2;
        return 1'b0;
    endfunction

    always_comb colisao = blocked(mode, int'(xCand), int'(yCand), int'(xPos));

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic do_reset();
        @(negedge VGA_clk);
        reset_n = 1'b0;
        repeat (2) @(negedge VGA_clk);
        reset_n = 1'b1;
        mx = 110;
        my = 60;
    endtask

    // One frame: model result first, then tick the DUT and wait for it to go idle.
    task automatic run_frame(input bit u, input bit d, input bit l, input bit r,
                             input bit scramble, input bit second_tick);
        int dx, dy, t, ex, ey, eb, nb, bud;
        bit seen;
        dx = (r && !l) ? 1 : (l && !r) ? -1 : 0;
        dy = (d && !u) ? 1 : (u && !d) ? -1 : 0;
        ex = mx; ey = my; eb = 0;
        if (dx != 0) begin
            t = clamp(mx + 2 * dx, 0, 620);
            if (t != mx) begin
                if (blocked(mode, t, my, mx)) eb++;
                else ex = t;
            end
        end
        if (dy != 0) begin
            t = clamp(my + 2 * dy, 0, 460);
            if (t != my) begin
                if (blocked(mode, ex, t, ex)) eb++;
                else ey = t;
            end
        end
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        frame_tick = 1'b1;
        @(negedge VGA_clk);
        frame_tick = 1'b0;
        if (scramble) {btn_up, btn_down, btn_left, btn_right} = 4'($urandom);
        seen = busy;
        nb = 0; bud = 0;
        while (busy && bud < 30) begin
            if (bloqueado) nb++;
            @(negedge VGA_clk);
            bud++;
            if (second_tick && bud == 1) frame_tick = 1'b1;
            else frame_tick = 1'b0;
        end
        if (bloqueado) nb++;
        if (bud >= 30) chk("frame_timeout", 1, 0);
        chk("frame_busy", int'(seen), int'(dx != 0 || dy != 0));
        chk("frame_x", int'(xPos), ex);
        chk("frame_y", int'(yPos), ey);
        chk("frame_bloq", nb, eb);
        mx = ex; my = ey;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0;
    endtask

    initial begin
        // Reset with a button held: nothing moves until a tick.
        btn_right = 1'b1;
        do_reset();
        chk("rst_x", int'(xPos), 110);
        chk("rst_y", int'(yPos), 60);
        chk("rst_xc", int'(xCand), 110);
        chk("rst_yc", int'(yCand), 60);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bloq", int'(bloqueado), 0);
        chk("rst_perd", int'(frame_perdido), 0);
        chk("tamanho", int'(tamanho), 20);
        repeat (5) @(negedge VGA_clk);
        chk("idle_x", int'(xPos), 110);
        chk("idle_busy", int'(busy), 0);

        // Cycle-accurate single X move.
        frame_tick = 1'b1;
        @(negedge VGA_clk);
        frame_tick = 1'b0;
        btn_right = 1'b0;
        chk("t2_busy0", int'(busy), 1);
        @(negedge VGA_clk);
        chk("t2_xcand", int'(xCand), 112);
        chk("t2_ycand", int'(yCand), 60);
        @(negedge VGA_clk);
        chk("t2_x_wait", int'(xPos), 110);
        @(negedge VGA_clk);
        chk("t2_x_commit", int'(xPos), 112);
        chk("t2_busy3", int'(busy), 1);
        @(negedge VGA_clk);
        chk("t2_busy4", int'(busy), 0);
        mx = 112;

        // X probe blocked, Y probe free.
        mode = 1;
        run_frame(1, 0, 1, 0, 0, 0);
        chk("t3_x", int'(xPos), 112);
        chk("t3_y", int'(yPos), 58);

        mode = 2;
        repeat (120) run_frame($urandom_range(1), $urandom_range(1), $urandom_range(1),
                               $urandom_range(1), 1, 0);

        // Left edge, then a frame with nothing to probe.
        mode = 0;
        do_reset();
        repeat (56) run_frame(0, 0, 1, 0, 0, 0);
        chk("t4_x0", int'(xPos), 0);
        run_frame(0, 0, 1, 0, 0, 0);

        // Bottom clamp with both horizontal buttons pressed.
        repeat (205) run_frame(0, 1, 1, 1, 0, 0);
        chk("t5_y", int'(yPos), 460);
        chk("t5_x", int'(xPos), 0);
        repeat (312) run_frame(0, 0, 0, 1, 0, 0);
        chk("t5_xmax", int'(xPos), 620);

        // Tick while busy is dropped and flagged.
        chk("t6_perd0", int'(frame_perdido), 0);
        run_frame(1, 0, 1, 0, 0, 1);
        chk("t6_perd1", int'(frame_perdido), 1);
        repeat (3) @(negedge VGA_clk);
        chk("t6_perd_sticky", int'(frame_perdido), 1);

        // Reset landing inside WAIT_Y.
        btn_left = 1'b1; btn_up = 1'b1;
        frame_tick = 1'b1;
        @(negedge VGA_clk);
        frame_tick = 1'b0;
        repeat (4) @(negedge VGA_clk);
        reset_n = 1'b0;
        @(negedge VGA_clk);
        chk("t6_rst_x", int'(xPos), 110);
        chk("t6_rst_y", int'(yPos), 60);
        chk("t6_rst_xc", int'(xCand), 110);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_perd", int'(frame_perdido), 0);
        reset_n = 1'b1;
        btn_left = 1'b0; btn_up = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
